// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum stage is enabled with IMEM_BOOT_LOADER_CHECKSUM_EN.
package imem_boot_loader_pkg;

    localparam int NUM_BANKS   = 4;
    localparam int SRAM_ADDR_W = 9;
    localparam int SRAM_DATA_W = 8;
    localparam int WORD_W      = NUM_BANKS * SRAM_DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        CHECK,
        RUN,
        ERROR
    } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer: four byte lanes filled in order 0..3,
// with a one-cycle word_valid pulse after lane 3 has been captured.
module imem_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  byte_en,
    input  logic [SRAM_DATA_W-1:0]                byte_in,
    output logic [1:0]                            byte_cnt,
    output logic [NUM_BANKS-1:0][SRAM_DATA_W-1:0] word,
    output logic                                  word_valid
);

    // Capture accepted byte into the current lane; the lane counter wraps 3->0.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && (byte_cnt == 2'd3);
            if (byte_en) begin
                word[byte_cnt] <= byte_in;
                byte_cnt       <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time imem loader: packs a byte stream into 32-bit words, writes them
// across the four 512x8 banks (one byte lane per bank), holds the core in
// reset meanwhile, then hands the bank ports to the core fetch path.
// Define IMEM_BOOT_LOADER_CHECKSUM_EN to require a trailing 4-byte LE sum
// of all written words before releasing the core.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int NUM_WORDS = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   skip_load,
    input  logic                   in_valid,
    input  logic [SRAM_DATA_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   core_rst,
    output logic                   done,
    output logic                   err,
    input  logic                   CEN_core  [0:NUM_BANKS-1],
    input  logic                   GWEN_core [0:NUM_BANKS-1],
    input  logic [SRAM_DATA_W-1:0] WEN_core  [0:NUM_BANKS-1],
    input  logic [SRAM_ADDR_W-1:0] A_core    [0:NUM_BANKS-1],
    input  logic [SRAM_DATA_W-1:0] D_core    [0:NUM_BANKS-1],
    output logic                   CEN_imem  [0:NUM_BANKS-1],
    output logic                   GWEN_imem [0:NUM_BANKS-1],
    output logic [SRAM_DATA_W-1:0] WEN_imem  [0:NUM_BANKS-1],
    output logic [SRAM_ADDR_W-1:0] A_imem    [0:NUM_BANKS-1],
    output logic [SRAM_DATA_W-1:0] D_imem    [0:NUM_BANKS-1]
);

    state_t                                state, state_nxt;
    logic   [SRAM_ADDR_W-1:0]              word_addr;
    logic   [1:0]                          byte_cnt;
    logic   [NUM_BANKS-1:0][SRAM_DATA_W-1:0] word;
    logic   [WORD_W-1:0]                   word_flat;
    logic                                  word_valid;
    logic                                  accept;
    logic                                  last_byte;
    logic                                  last_word;
    logic                                  wr_en;

    assign accept    = in_valid && in_ready;
    assign last_byte = accept && (byte_cnt == 2'd3);
    assign last_word = (word_addr == SRAM_ADDR_W'(NUM_WORDS - 1));
    assign word_flat = word;
    // The packer pulses word_valid exactly in the WRITE cycle; gating with it
    // keeps a write from ever firing on a half-filled word.
    assign wr_en     = (state == WRITE) && word_valid;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_en    (accept),
        .byte_in    (in_data),
        .byte_cnt   (byte_cnt),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum;
    logic              sum_ok;

    // Last checksum byte is still on in_data, so compare against it directly.
    assign sum_ok = ({in_data, word_flat[23:0]} == sum);

    // Running mod-2^32 sum of every word written to the banks.
    always_ff @(posedge clk) begin
        if (rst)        sum <= '0;
        else if (wr_en) sum <= sum + word_flat;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; RUN and ERROR are left only through rst.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start)     state_nxt = LOAD;
                else if (skip_load) state_nxt = RUN;
            end
            LOAD: begin
                if (last_byte) state_nxt = WRITE;
            end
            WRITE: begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                state_nxt = last_word ? CHECK : LOAD;
`else
                state_nxt = last_word ? RUN : LOAD;
`endif
            end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            CHECK: begin
                if (last_byte) state_nxt = sum_ok ? RUN : ERROR;
            end
            ERROR: state_nxt = ERROR;
`endif
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Word address advances after each write except the last.
    always_ff @(posedge clk) begin
        if (rst)                     word_addr <= '0;
        else if (wr_en && !last_word) word_addr <= word_addr + 1'b1;
    end

    // Status outputs and bank port mux: core pass-through in RUN, loader otherwise.
    always_comb begin
        in_ready = (state == LOAD) || (state == CHECK);
        core_rst = (state != RUN);
        done     = (state == RUN);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        err      = (state == ERROR);
`else
        err      = 1'b0;
`endif
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (state == RUN) begin
                CEN_imem[i]  = CEN_core[i];
                GWEN_imem[i] = GWEN_core[i];
                WEN_imem[i]  = WEN_core[i];
                A_imem[i]    = A_core[i];
                D_imem[i]    = D_core[i];
            end else begin
                CEN_imem[i]  = !wr_en;
                GWEN_imem[i] = !wr_en;
                WEN_imem[i]  = wr_en ? '0 : '1;
                A_imem[i]    = word_addr;
                D_imem[i]    = word[i];
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader (NUM_WORDS=8) with a byte-level
// reference model of the four imem banks.
module tb_imem_boot_loader;

    localparam int NW = 8;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    localparam int CK_BYTES = 4;
`else
    localparam int CK_BYTES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       skip_load = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, core_rst, done, err;
    logic       CEN_core  [0:3];
    logic       GWEN_core [0:3];
    logic [7:0] WEN_core  [0:3];
    logic [8:0] A_core    [0:3];
    logic [7:0] D_core    [0:3];
    logic       CEN_imem  [0:3];
    logic       GWEN_imem [0:3];
    logic [7:0] WEN_imem  [0:3];
    logic [8:0] A_imem    [0:3];
    logic [7:0] D_imem    [0:3];

    imem_boot_loader #(.NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .skip_load(skip_load),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_rst(core_rst), .done(done), .err(err),
        .CEN_core(CEN_core), .GWEN_core(GWEN_core), .WEN_core(WEN_core),
        .A_core(A_core), .D_core(D_core),
        .CEN_imem(CEN_imem), .GWEN_imem(GWEN_imem), .WEN_imem(WEN_imem),
        .A_imem(A_imem), .D_imem(D_imem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    int         vecs = 0;
    int         errs = 0;
    wr_t        exp_q [$];
    logic [7:0] stream [$];
    logic [7:0] bank [0:3][0:511];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every loader write must match the next expected word.
    always @(negedge clk) begin : mon
        logic [3:0] cen;
        wr_t        e;
        for (int i = 0; i < 4; i++) cen[i] = CEN_imem[i];
        if (!rst && core_rst && cen != 4'hF) begin
            chk("write_was_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_cen_all", 64'(cen), 64'h0);
                for (int i = 0; i < 4; i++) begin
                    chk("wr_gwen", 64'(GWEN_imem[i]), 64'd0);
                    chk("wr_wen", 64'(WEN_imem[i]), 64'h00);
                    chk("wr_addr", 64'(A_imem[i]), 64'(e.addr));
                    chk("wr_data", 64'(D_imem[i]), 64'(e.data[8*i +: 8]));
                    bank[i][A_imem[i]] = D_imem[i];
                end
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one byte, with random idle cycles, until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int t = 0;
        bit taken = 1'b0;
        while (!taken) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gap_pct) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                in_data  = b;
            end
            taken = in_valid && in_ready;
            @(posedge clk);
            t++;
            if (t > 200) begin
                vecs++;
                errs++;
                $display("FAIL byte_timeout: byte %0h not accepted in 200 cycles", b);
                return;
            end
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    // Reference: word w is bytes 4w..4w+3 little-endian at address w.
    task automatic load_stream(input int gap, input bit corrupt, input bit inc);
        logic [31:0] sum = 32'd0;
        logic [31:0] wd;
        stream.delete();
        for (int k = 0; k < 4 * NW; k++) stream.push_back(inc ? 8'(k) : 8'($urandom));
        for (int w = 0; w < NW; w++) begin
            wd = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
            exp_q.push_back('{addr: 9'(w), data: wd});
            sum += wd;
        end
        if (corrupt) sum += 32'd1;
        for (int k = 0; k < 4 * NW; k++) send_byte(stream[k], gap);
        for (int k = 0; k < CK_BYTES; k++) send_byte(sum[8*k +: 8], gap);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!(done || err) && n < 600) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_banks();
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < 4; i++)
                chk("bank_content", 64'(bank[i][w]), 64'(stream[4*w+i]));
    endtask

    task automatic run_load(input int gap, input bit corrupt, input bit inc, input bit timed);
        int n;
        start_load();
        fork
            load_stream(gap, corrupt, inc);
            wait_end(n);
        join
        if (timed) chk("done_latency", 64'(n), 64'(5 * NW + CK_BYTES));
        if (!corrupt) begin
            chk("done_after_load", 64'(done), 64'd1);
            chk("core_rst_after_load", 64'(core_rst), 64'd0);
            chk("err_after_load", 64'(err), 64'd0);
            chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
            check_banks();
        end
    endtask

    initial begin : stim
        logic [3:0] v;
        for (int i = 0; i < 4; i++) begin
            CEN_core[i] = 1'b1; GWEN_core[i] = 1'b1; WEN_core[i] = 8'hFF;
            A_core[i] = '0; D_core[i] = '0;
        end

        // Reset state
        do_reset(3);
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        for (int i = 0; i < 4; i++) v[i] = CEN_imem[i];
        chk("rst_cen", 64'(v), 64'hF);
        for (int i = 0; i < 4; i++) begin
            chk("rst_wen", 64'(WEN_imem[i]), 64'hFF);
            chk("rst_addr", 64'(A_imem[i]), 64'h0);
            chk("rst_data", 64'(D_imem[i]), 64'h0);
        end

        // Incrementing stream, in_valid held high
        run_load(0, 1'b0, 1'b1, 1'b1);

        // load_start in RUN is ignored
        start_load();
        repeat (3) @(negedge clk);
        chk("run_ignores_load_start", 64'(done), 64'd1);
        chk("run_in_ready", 64'(in_ready), 64'd0);

        // Random data with 50% in_valid gaps
        do_reset(2);
        run_load(50, 1'b0, 1'b0, 1'b0);
        do_reset(2);
        run_load(30, 1'b0, 1'b0, 1'b0);

        // rst after 3 bytes: partial word discarded, nothing written
        do_reset(2);
        start_load();
        for (int k = 0; k < 3; k++) send_byte(8'hA0 + 8'(k), 0);
        do_reset(2);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_no_write", 64'(exp_q.size()), 64'd0);
        run_load(0, 1'b0, 1'b0, 1'b1);

        // skip_load: RUN next cycle, core ports pass through combinationally
        do_reset(2);
        for (int i = 0; i < 4; i++) CEN_core[i] = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) v[i] = CEN_imem[i];
        chk("idle_ignores_core", 64'(v), 64'hF);
        @(negedge clk);
        skip_load = 1'b1;
        @(posedge clk);
        #1 skip_load = 1'b0;
        @(negedge clk);
        chk("skip_done", 64'(done), 64'd1);
        chk("skip_core_rst", 64'(core_rst), 64'd0);
        A_core[2] = 9'h1A5;
        CEN_core[2] = 1'b0;
        #1;
        chk("pass_a2", 64'(A_imem[2]), 64'h1A5);
        chk("pass_cen2", 64'(CEN_imem[2]), 64'd0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                CEN_core[i] = 1'($urandom); GWEN_core[i] = 1'($urandom);
                WEN_core[i] = 8'($urandom); A_core[i] = 9'($urandom); D_core[i] = 8'($urandom);
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                chk("pass_cen", 64'(CEN_imem[i]), 64'(CEN_core[i]));
                chk("pass_gwen", 64'(GWEN_imem[i]), 64'(GWEN_core[i]));
                chk("pass_wen", 64'(WEN_imem[i]), 64'(WEN_core[i]));
                chk("pass_a", 64'(A_imem[i]), 64'(A_core[i]));
                chk("pass_d", 64'(D_imem[i]), 64'(D_core[i]));
            end
            @(negedge clk);
        end

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        // Bad checksum: sticky error, core held in reset
        do_reset(2);
        run_load(0, 1'b1, 1'b0, 1'b0);
        chk("bad_sum_err", 64'(err), 64'd1);
        for (int r = 0; r < 10; r++) begin
            repeat (10) @(negedge clk);
            chk("err_held", 64'(err), 64'd1);
            chk("err_core_rst", 64'(core_rst), 64'd1);
            chk("err_done", 64'(done), 64'd0);
            chk("err_in_ready", 64'(in_ready), 64'd0);
            chk("err_cen", 64'(CEN_imem[0]), 64'd1);
        end
        chk("err_writes_outstanding", 64'(exp_q.size()), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", errs);
        $fatal(1, "watchdog expired");
    end

endmodule
